// File: rtl/reg_file_mp_pkg.sv
// Shared FSM state type and default sizing for the multi-port register file.
package reg_file_mp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/reg_file_mp_rd_port.sv
// One read port of reg_file_mp: address mux, optional write bypass and registered output.
// Same-cycle write forwarding is compiled in when REG_FILE_MP_BYPASS_EN is defined.
module reg_file_mp_rd_port
    import reg_file_mp_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  i_regs,
    input  logic                          i_wrHit,
    input  logic [ADDR_W-1:0]             i_wrAddr,
    input  logic [DATA_W-1:0]             i_wrData,
    output logic [DATA_W-1:0]             o_data
);

    logic [DATA_W-1:0] w_nextData;
    logic [DATA_W-1:0] r_data;

`ifdef REG_FILE_MP_BYPASS_EN
    // i_wrHit already excludes address 0, so register 0 is never forwarded.
    always_comb begin
        w_nextData = i_regs[i_addr];
        if (i_wrHit && (i_wrAddr == i_addr)) begin
            w_nextData = i_wrData;
        end
    end
`else
    logic w_unusedBypass;
    assign w_unusedBypass = ^{i_wrHit, i_wrAddr, i_wrData};

    always_comb begin
        w_nextData = i_regs[i_addr];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_nextData;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file (r0 hardwired to zero) with a one-register-per-cycle clear sweep.
// Define REG_FILE_MP_BYPASS_EN to forward an accepted same-cycle write to matching reads.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    parameter int  NUM_RD = DEF_NUM_RD,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           w_en,
    input  logic [ADDR_W-1:0]              rd,
    input  logic [DATA_W-1:0]              rdv,
    output logic                           w_ready,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rs_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rs_data,
    input  logic                           clr,
    output logic                           busy,
    output logic                           wr_drop
);

    state_t                       r_state;
    state_t                       w_nextState;
    logic [DEPTH-1:0][DATA_W-1:0] r_regs;
    logic [ADDR_W-1:0]            r_sweepIdx;
    logic                         r_wrDrop;
    logic                         w_busy;
    logic                         w_wrHit;
    logic                         w_sweepLast;

    assign w_sweepLast = (r_sweepIdx == ADDR_W'(DEPTH - 1));
    assign w_wrHit     = w_en && !w_busy && (rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (clr)         w_nextState = CLEAR;
            CLEAR:   if (w_sweepLast) w_nextState = IDLE;
            default:                  w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            CLEAR:   w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    assign busy    = w_busy;
    assign w_ready = !w_busy;

    // A clr arriving mid-sweep never reloads the index, so the sweep cannot restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweepIdx <= '0;
        end else if (!w_busy && clr) begin
            r_sweepIdx <= ADDR_W'(1);
        end else if (w_busy) begin
            r_sweepIdx <= r_sweepIdx + 1'b1;
        end
    end

    // Writes are only accepted while idle, so they never collide with the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
        end else if (w_busy) begin
            r_regs[r_sweepIdx] <= '0;
        end else if (w_wrHit) begin
            r_regs[rd] <= rdv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrDrop <= 1'b0;
        end else if (w_en && w_busy) begin
            r_wrDrop <= 1'b1;
        end
    end

    assign wr_drop = r_wrDrop;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rdPort
        reg_file_mp_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_rdPort (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_addr   (rs_addr[g]),
            .i_regs   (r_regs),
            .i_wrHit  (w_wrHit),
            .i_wrAddr (rd),
            .i_wrData (rdv),
            .o_data   (rs_data[g])
        );
    end

endmodule
